// File: rtl/pipe_stall_sequencer.sv
// Pipeline sequencing controller: merges hazard and memory-wait stalls into final stage enables/flushes and owns the PC redirect path.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush/redirect performance counters.
//
// state        | meaning
// RUN          | pipeline flowing, hazard-unit requests passed through
// FETCH_WAIT   | instruction fetch outstanding, D receives bubbles
// MEM_WAIT     | data access outstanding, whole pipe frozen
// REDIR_HOLD   | branch taken during a fetch wait, target held until the stale response drains
module pipe_stall_sequencer #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall_F_h,
  input  logic            Stall_D_h,
  input  logic            Flush_D_h,
  input  logic            Flush_E_h,
  input  logic            PCSrc_E,
  input  logic [XLEN-1:0] PCTarget_E,
  input  logic            imem_ready,
  input  logic            dmem_req_M,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            En_F,
  output logic            En_D,
  output logic            En_E,
  output logic            En_M,
  output logic            En_W,
  output logic            Flush_D,
  output logic            Flush_E,
  output logic            Flush_M,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            timeout_err,
  output logic [1:0]      state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_redir_cnt
`endif
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_FETCH_WAIT = 2'b01,
    ST_MEM_WAIT   = 2'b10,
    ST_REDIR_HOLD = 2'b11
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_target, w_target_nxt;
  logic [CW-1:0]     r_wait_cnt, w_wait_cnt_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic w_mem_stall;
  logic w_fetch_stall;

  assign w_mem_stall   = dmem_req_M & ~dmem_ready;
  assign w_fetch_stall = ~imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_target   <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    imem_req       = 1'b1;
    En_F           = 1'b0;
    En_D           = 1'b0;
    En_E           = 1'b0;
    En_M           = 1'b0;
    En_W           = 1'b0;
    Flush_D        = 1'b0;
    Flush_E        = 1'b0;
    Flush_M        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = PCTarget_E;

    case (r_state)
      ST_REDIR_HOLD: begin
        redirect_pc = r_target;
        Flush_D     = 1'b1;
        if (!w_mem_stall) begin
          En_D    = 1'b1;
          En_E    = 1'b1;
          En_M    = 1'b1;
          En_W    = 1'b1;
          Flush_E = Flush_E_h;
          if (imem_ready) begin
            En_F           = 1'b1;
            redirect_valid = 1'b1;
            w_state_nxt    = ST_RUN;
          end
        end
      end
      // RUN, FETCH_WAIT and the completing MEM_WAIT cycle obey the same rules.
      default: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          En_F           = ~Stall_F_h;
          En_D           = ~Stall_D_h;
          En_E           = 1'b1;
          En_M           = 1'b1;
          En_W           = 1'b1;
          Flush_D        = Flush_D_h;
          Flush_E        = Flush_E_h;
          redirect_valid = PCSrc_E;
          w_state_nxt    = ST_RUN;
          if (w_fetch_stall) begin
            En_F = 1'b0;
            if (PCSrc_E) begin
              En_D           = 1'b1;
              Flush_D        = 1'b1;
              Flush_E        = 1'b1;
              redirect_valid = 1'b0;
              w_target_nxt   = PCTarget_E;
              w_state_nxt    = ST_REDIR_HOLD;
            end else begin
              En_D        = ~Stall_D_h;
              Flush_D     = ~Stall_D_h;
              w_state_nxt = ST_FETCH_WAIT;
            end
          end
        end
      end
    endcase

    if (rst) begin
      imem_req       = 1'b0;
      En_F           = 1'b0;
      En_D           = 1'b0;
      En_E           = 1'b0;
      En_M           = 1'b0;
      En_W           = 1'b0;
      Flush_D        = 1'b0;
      Flush_E        = 1'b0;
      Flush_M        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_state_nxt == ST_RUN) begin
      w_wait_cnt_nxt = '0;
    end else if (r_state != ST_RUN && r_wait_cnt != LP_MAX) begin
      w_wait_cnt_nxt = r_wait_cnt + CW'(1);
    end
    w_timeout_nxt = r_timeout | ((r_state != ST_RUN) && (w_wait_cnt_nxt == LP_MAX));
  end

  assign timeout_err = r_timeout & ~rst;
  assign state_o     = rst ? 2'b00 : r_state;

`ifdef PIPE_PERF_CNT_EN
  logic w_any_en_low;
  logic w_any_flush;

  assign w_any_en_low = ~(En_F & En_D & En_E & En_M & En_W);
  assign w_any_flush  = Flush_D | Flush_E | Flush_M;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_redir_cnt <= '0;
    end else begin
      if (w_any_en_low && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (w_any_flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (redirect_valid && perf_redir_cnt != '1) perf_redir_cnt <= perf_redir_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
